fir_output_collector: RTL and testbench

- Sink-side companion to the Booth FIR filter. It samples the filter's 4-bit output once per input-sample period, in step with the source strobe.
- Captured samples are buffered in a small FIFO and streamed to a downstream consumer over a valid/ready interface.
- It counts dropped samples so a bench or logic analyser can drain filter results at its own rate.

---
 rtl/fir_cap_pkg.sv | 21 ++
 rtl/fir_cap_fifo.sv | 66 ++++++
 rtl/fir_output_collector.sv | 156 +++++++++++++++
 tb/tb_fir_output_collector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_cap_pkg.sv
// Shared types and defaults for the FIR output collector.
// Optional capture tagging is enabled by defining FIR_CAPTURE_TAG_EN.
package fir_cap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } cap_state_e;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 16;
    localparam int STRIDE_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    // Occupancy needs one bit beyond the pointer width so that full and empty differ.
    function automatic int fill_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fir_cap_fifo.sv
// First-word-fall-through FIFO for captured FIR samples.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
// The head output holds the last shown word while the FIFO is empty.
module fir_cap_fifo
    import fir_cap_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head,
    output logic                      empty,
    output logic                      full,
    output logic [fill_w(DEPTH)-1:0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = fill_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [LW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic             do_push, do_pop;

    // Occupancy, flags and accept decisions.
    always_comb begin
        level    = wr_cnt_q - rd_cnt_q;
        empty    = (level == '0);
        full     = (level == LW'(DEPTH));
        wr_idx   = wr_cnt_q[AW-1:0];
        rd_idx   = rd_cnt_q[AW-1:0];
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_cnt_d = do_push ? wr_cnt_q + 1'b1 : wr_cnt_q;
        rd_cnt_d = do_pop  ? rd_cnt_q + 1'b1 : rd_cnt_q;
        last_d   = empty ? last_q : mem[rd_idx];
        head     = empty ? last_q : mem[rd_idx];
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Pointer counters and the held head value.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            last_q   <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/fir_output_collector.sv
// Samples the FIR filter output once per stride while enabled, buffers the
// captures in a FWFT FIFO and streams them out over valid/ready.
// Drops on a full FIFO are counted in a saturating counter.
// Define FIR_CAPTURE_TAG_EN to add out_tag, a per-strobe index stored with each sample.
//
// state | meaning
// IDLE  | not capturing, phase held
// RUN   | phase counting, capture on phase == STRIDE-1
// DRAIN | capture stopped, FIFO still draining; goes IDLE when empty
module fir_output_collector
    import fir_cap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STRIDE = STRIDE_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [DATA_W-1:0]         sample_in,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [fill_w(DEPTH)-1:0]  fill_level,
    output logic [CNT_W-1:0]          overflow_cnt,
`ifdef FIR_CAPTURE_TAG_EN
    output logic [CNT_W-1:0]          out_tag,
`endif
    output logic                      busy
);

    localparam int PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(STRIDE - 1);

`ifdef FIR_CAPTURE_TAG_EN
    localparam int FW = DATA_W + CNT_W;
`else
    localparam int FW = DATA_W;
`endif

    cap_state_e              state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [CNT_W-1:0]        ovf_q, ovf_d;
    logic                    capture;
    logic                    pop_eff;
    logic                    drop;
    logic                    fifo_empty, fifo_full;
    logic [FW-1:0]           fifo_wdata, fifo_head;
    logic [fill_w(DEPTH)-1:0] fifo_level;

    // Next state, phase and capture strobe.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    phase_d = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = DRAIN;
                end else begin
                    capture = (phase_q == PH_LAST);
                    phase_d = capture ? '0 : phase_q + 1'b1;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                    phase_d = '0;
                end else if (fifo_empty) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Drop accounting: a capture is lost only if the FIFO is full and nothing leaves.
    always_comb begin
        pop_eff = ~fifo_empty & out_ready;
        drop    = capture & fifo_full & ~pop_eff;
        ovf_d   = (drop && (ovf_q != '1)) ? ovf_q + 1'b1 : ovf_q;
    end

    // FSM, phase and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef FIR_CAPTURE_TAG_EN
    logic [CNT_W-1:0] idx_q, idx_d;

    // Strobe index advances on every capture attempt, dropped or not.
    always_comb begin
        idx_d      = capture ? idx_q + 1'b1 : idx_q;
        fifo_wdata = {idx_q, sample_in};
        out_tag    = fifo_head[FW-1:DATA_W];
    end

    // Strobe index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end
`else
    // Untagged FIFO word is the raw sample.
    always_comb begin
        fifo_wdata = sample_in;
    end
`endif

    fir_cap_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (fifo_wdata),
        .pop       (out_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    // Output mapping.
    always_comb begin
        out_data     = fifo_head[DATA_W-1:0];
        out_valid    = ~fifo_empty;
        fill_level   = fifo_level;
        overflow_cnt = ovf_q;
        busy         = (state_q != IDLE);
    end

endmodule

// File: tb/tb_fir_output_collector.sv
// Randomised bench for fir_output_collector with an in-bench queue model.
// A second instance with a 2-bit counter width exercises overflow saturation.
module tb_fir_output_collector;

    localparam int DW = 4;
    localparam int ST = 8;
    localparam int DP = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          out_ready = 1'b0;

    logic [DW-1:0] out_data, d2_data;
    logic          out_valid, d2_valid;
    logic [3:0]    fill_level, d2_fill;
    logic [CW-1:0] overflow_cnt;
    logic [1:0]    d2_ovf;
    logic          busy, d2_busy;
`ifdef FIR_CAPTURE_TAG_EN
    logic [CW-1:0] out_tag;
    logic [1:0]    d2_tag;
`endif

    always #5 clk = ~clk;

    fir_output_collector #(.DATA_W(DW), .STRIDE(ST), .DEPTH(DP), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_in    (sample_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fill_level   (fill_level),
        .overflow_cnt (overflow_cnt),
`ifdef FIR_CAPTURE_TAG_EN
        .out_tag      (out_tag),
`endif
        .busy         (busy)
    );

    fir_output_collector #(.DATA_W(DW), .STRIDE(ST), .DEPTH(DP), .CNT_W(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_in    (sample_in),
        .out_data     (d2_data),
        .out_valid    (d2_valid),
        .out_ready    (out_ready),
        .fill_level   (d2_fill),
        .overflow_cnt (d2_ovf),
`ifdef FIR_CAPTURE_TAG_EN
        .out_tag      (d2_tag),
`endif
        .busy         (d2_busy)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int data;
        int tag;
    } ent_t;

    ent_t q[$];
    int   m_mode = 0;     // 0 idle, 1 capturing, 2 draining
    int   m_cnt  = 0;     // cycles since capture (re)started, modulo stride
    int   m_ovf  = 0;     // drops, unsaturated
    int   m_idx  = 0;     // strobes since reset
    int   m_last = 0;     // value shown while empty

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        bit pop, cap, was_full;
        if (rst) begin
            q.delete();
            m_mode = 0;
            m_cnt  = 0;
            m_ovf  = 0;
            m_idx  = 0;
            m_last = 0;
        end else begin
            pop      = (q.size() > 0) && out_ready;
            was_full = (q.size() == DP);
            cap      = (m_mode == 1) && en && (m_cnt == ST - 1);
            if (m_mode == 0) begin
                if (en) begin m_mode = 1; m_cnt = 0; end
            end else if (m_mode == 1) begin
                if (!en) m_mode = 2;
                else     m_cnt = (m_cnt + 1) % ST;
            end else begin
                if (en) begin m_mode = 1; m_cnt = 0; end
                else if (q.size() == 0) m_mode = 0;
            end
            if (pop) begin
                m_last = q[0].data;
                void'(q.pop_front());
            end
            if (cap) begin
                if (!was_full || pop) q.push_back('{int'(sample_in), m_idx});
                else m_ovf++;
                m_idx = (m_idx + 1) % (1 << CW);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("out_data", 32'(out_data), (q.size() > 0) ? 32'(q[0].data) : 32'(m_last));
            check("fill_level", 32'(fill_level), 32'(q.size()));
            check("overflow_cnt", 32'(overflow_cnt), (m_ovf > 65535) ? 32'd65535 : 32'(m_ovf));
            check("busy", 32'(busy), 32'(m_mode != 0));
            check("d2_fill", 32'(d2_fill), 32'(q.size()));
            check("d2_ovf_sat", 32'(d2_ovf), (m_ovf > 3) ? 32'd3 : 32'(m_ovf));
`ifdef FIR_CAPTURE_TAG_EN
            if (q.size() > 0) begin
                check("out_tag", 32'(out_tag), 32'(q[0].tag));
                check("d2_tag", 32'(d2_tag), 32'(q[0].tag % 4));
            end
`endif
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            sample_in = DW'($urandom_range(0, 15));
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int thr;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);

        // reset holds everything at zero, even with en asserted
        step(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        en = 1'b1;
        step(2);
        check("rst_en_busy", 32'(busy), 32'd0);
        check("rst_en_valid", 32'(out_valid), 32'd0);

        // basic capture with consumer always ready
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        step(8);
        check("first_cap_not_yet", 32'(out_valid), 32'd0);
        sample_in = 4'hA;
        @(posedge clk); @(negedge clk);
        check("first_cap_valid", 32'(out_valid), 32'd1);
        check("first_cap_data", 32'(out_data), 32'hA);
        check("first_cap_fill", 32'(fill_level), 32'd1);
        step(20);

        // overflow: 10 strobes into a stalled consumer
        en = 1'b0; rst = 1'b1; step(1);
        rst = 1'b0; en = 1'b1; out_ready = 1'b0;
        step(81);
        check("ovf_fill8", 32'(fill_level), 32'd8);
        check("ovf_cnt2", 32'(overflow_cnt), 32'd2);
        check("model_ovf2", 32'(m_ovf), 32'd2);
        step(24);
        check("ovf_cnt5", 32'(overflow_cnt), 32'd5);
        check("ovf_sat3", 32'(d2_ovf), 32'd3);

        // full FIFO with a pop exactly on the strobe edge
        step(7);
        out_ready = 1'b1;
        sample_in = 4'h5;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("fullpop_cnt", 32'(overflow_cnt), 32'd5);
        check("fullpop_fill", 32'(fill_level), 32'd8);
        check("model_tail", 32'(q[DP-1].data), 32'h5);
`ifdef FIR_CAPTURE_TAG_EN
        check("fullpop_tag", 32'(out_tag), 32'd1);
        check("model_tail_tag", 32'(q[DP-1].tag), 32'd13);
`endif

        // reset mid-run clears everything in one edge
        rst = 1'b1; step(1);
        check("midrst_fill", 32'(fill_level), 32'd0);
        check("midrst_ovf", 32'(overflow_cnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        en = 1'b0; step(1);

        // drain: three entries queued, then en dropped
        rst = 1'b0; en = 1'b1; out_ready = 1'b0;
        step(25);
        check("drain_fill3", 32'(fill_level), 32'd3);
        en = 1'b0; out_ready = 1'b1;
        step(1);
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_fill2", 32'(fill_level), 32'd2);
        step(2);
        check("drain_empty", 32'(fill_level), 32'd0);
        check("drain_busy_last", 32'(busy), 32'd1);
        step(1);
        check("drain_idle", 32'(busy), 32'd0);

        // re-enable after one pop while draining
        en = 1'b1; out_ready = 1'b0;
        step(25);
        en = 1'b0; out_ready = 1'b1;
        step(1);
        en = 1'b1; out_ready = 1'b0;
        step(8);
        check("reen_keep2", 32'(fill_level), 32'd2);
        check("reen_busy", 32'(busy), 32'd1);
        step(1);
        check("reen_cap", 32'(fill_level), 32'd3);

        // randomised traffic
        thr = 2;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) thr = $urandom_range(0, 4);
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 29) == 0) en = ~en;
            out_ready = ($urandom_range(0, 3) < thr);
            step(1);
        end

        rst = 1'b1; en = 1'b0; step(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
